// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-dump run controller.
package regdump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    CAP,
    OUT,
    RUN,
    DONE
  } state_t;

  localparam logic [1:0] STOP_NONE    = 2'd0;
  localparam logic [1:0] STOP_HALT    = 2'd1;
  localparam logic [1:0] STOP_STABLE  = 2'd2;
  localparam logic [1:0] STOP_TIMEOUT = 2'd3;

  localparam int NUM_REGS = 32;

endpackage

// File: rtl/regdump_ctrl_pc_stable_det.sv
// Detects a PC that has not moved for STABLE_CYCLES consecutive run cycles.
module pc_stable_det #(
  parameter int STABLE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [31:0] pc,
  output logic        stable
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [31:0]   prev_pc;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_pc    <= '0;
      stable_cnt <= '0;
    end else if (clear) begin
      prev_pc    <= pc;
      stable_cnt <= '0;
    end else if (en) begin
      prev_pc <= pc;
      if (pc == prev_pc) begin
        if (stable_cnt != CNT_MAX)
          stable_cnt <= stable_cnt + CW'(1);
      end else begin
        stable_cnt <= '0;
      end
    end
  end

  // Uses the pre-update count so the stop fires on the last unchanged cycle.
  assign stable = en && (stable_cnt == CNT_MAX) && (pc == prev_pc);

endmodule

// File: rtl/regdump_ctrl.sv
// Run/dump controller: gates the CPU, detects end of program, then streams
// all architectural registers out through a valid/ready port.
module regdump_ctrl
  import regdump_pkg::*;
#(
  parameter int MAX_CYCLES    = 20000,
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      pc,
  input  logic             halt_in,
  output logic             cpu_run,
  output logic [4:0]       reg_sel,
  input  logic [31:0]      reg_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [4:0]       dump_idx,
  output logic [31:0]      dump_data,
  output logic             busy,
  output logic             done,
  output logic [1:0]       stop_reason,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  state_t     state, state_n;
  logic [4:0] idx;
  logic       launch;
  logic       stable;
  logic [1:0] stop_code;

  assign launch = start && (state == IDLE || state == DONE);

  pc_stable_det #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stable (
    .clk   (clk),
    .rst   (rst),
    .clear (launch),
    .en    (state == RUN),
    .pc    (pc),
    .stable(stable)
  );

  // Halt outranks PC-stable, which outranks the cycle limit.
  always_comb begin
    stop_code = STOP_NONE;
    if (halt_in)
      stop_code = STOP_HALT;
    else if (stable)
      stop_code = STOP_STABLE;
    else if (cycle_count == CNT_W'(MAX_CYCLES - 1))
      stop_code = STOP_TIMEOUT;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start) state_n = RUN;
      RUN:        if (stop_code != STOP_NONE) state_n = SEL;
      SEL:        state_n = CAP;
      CAP:        state_n = OUT;
      OUT:        if (dump_ready) state_n = (idx == LAST_IDX) ? DONE : SEL;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count <= '0;
      stop_reason <= STOP_NONE;
      idx         <= '0;
      reg_sel     <= '0;
      dump_valid  <= 1'b0;
      dump_idx    <= '0;
      dump_data   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cycle_count <= '0;
            stop_reason <= STOP_NONE;
          end
        end
        RUN: begin
          cycle_count <= cycle_count + CNT_W'(1);
          if (stop_code != STOP_NONE) begin
            stop_reason <= stop_code;
            idx         <= '0;
          end
        end
        SEL: reg_sel <= idx;
        // x0 is hard-wired zero regardless of what the debug port returns.
        CAP: begin
          dump_data  <= (idx == 5'd0) ? 32'd0 : reg_data;
          dump_idx   <= idx;
          dump_valid <= 1'b1;
        end
        OUT: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (idx != LAST_IDX)
              idx <= idx + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_run = (state == RUN);
  assign busy    = (state == RUN) || (state == SEL) || (state == CAP) || (state == OUT);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_regdump_ctrl.sv
// Directed self-checking bench for regdump_ctrl (MAX_CYCLES=50, STABLE_CYCLES=8).
module tb_regdump_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, halt_in, dump_ready;
  logic [31:0] pc, reg_data;
  logic        cpu_run, dump_valid, busy, done;
  logic [4:0]  reg_sel, dump_idx;
  logic [31:0] dump_data;
  logic [1:0]  stop_reason;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  regdump_ctrl #(
    .MAX_CYCLES   (50),
    .STABLE_CYCLES(8),
    .CNT_W        (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pc         (pc),
    .halt_in    (halt_in),
    .cpu_run    (cpu_run),
    .reg_sel    (reg_sel),
    .reg_data   (reg_data),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .busy       (busy),
    .done       (done),
    .stop_reason(stop_reason),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Register file model behind the debug port; x0 deliberately non-zero here.
  function automatic logic [31:0] rf_val(input logic [4:0] k);
    return 32'hC0DE_0000 + 32'(k) * 32'h0001_0011;
  endfunction

  assign reg_data = rf_val(reg_sel);

  // Called at a negedge in IDLE/DONE; returns at the negedge of RUN cycle 1.
  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (cpu_run !== 1'b1 || cycle_count !== 32'd0 || done !== 1'b0 || stop_reason !== 2'd0) begin
      errors++;
      $display("[TB] FAIL start_clear: run=%b cnt=%0d done=%b reason=%0d, want 1 0 0 0",
               cpu_run, cycle_count, done, stop_reason);
    end
  endtask

  // Drives n RUN cycles; pc becomes 0x60 from cycle hold_from (0 = never).
  task automatic run_cycles(input int n, input int halt_at, input int hold_from);
    for (int k = 1; k <= n; k++) begin
      pc      = (hold_from > 0 && k >= hold_from) ? 32'h60 : 32'h1000 + 32'(4 * k);
      halt_in = (k == halt_at);
      if (k == n) begin
        checks++;
        if (cpu_run !== 1'b1) begin
          errors++;
          $display("[TB] FAIL early_stop: cpu_run=%b in cycle %0d, want 1", cpu_run, k);
        end
      end
      @(negedge clk);
    end
    halt_in = 1'b0;
    pc      = pc + 32'd4;
  endtask

  // Consumes beats; optionally stalls 5 cycles at stall_idx or stops at stop_at.
  task automatic collect_dump(input int stall_idx, input int stop_at,
                              input logic [1:0] exp_reason, input logic [31:0] exp_count);
    int exp_i = 0;
    int stalled = 0;
    int guard = 0;
    logic [31:0] exp_data;
    while (exp_i < 32 && guard < 500) begin
      if (dump_valid) begin
        exp_data = (exp_i == 0) ? 32'd0 : rf_val(exp_i[4:0]);
        checks++;
        if (dump_idx !== exp_i[4:0] || dump_data !== exp_data) begin
          errors++;
          $display("[TB] FAIL beat: idx=%0d data=%h, want idx=%0d data=%h",
                   dump_idx, dump_data, exp_i, exp_data);
        end
        if (exp_i == stop_at) begin
          dump_ready = 1'b0;
          return;
        end
        if (exp_i == stall_idx && stalled < 5) begin
          if (stalled > 0) begin
            checks++;
            if (reg_sel !== exp_i[4:0]) begin
              errors++;
              $display("[TB] FAIL stall_sel: reg_sel=%0d, want %0d", reg_sel, exp_i);
            end
          end
          dump_ready = 1'b0;
          stalled++;
        end else begin
          dump_ready = 1'b1;
          exp_i++;
        end
      end else begin
        if (stalled > 0 && stalled < 5) begin
          checks++;
          errors++;
          $display("[TB] FAIL stall_valid: dump_valid=0 during stall, want 1");
        end
        dump_ready = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    checks++;
    if (exp_i != 32) begin
      errors++;
      $display("[TB] FAIL dump_timeout: got %0d beats, want 32", exp_i);
    end else if (done !== 1'b1 || dump_valid !== 1'b0 || busy !== 1'b0 ||
                 stop_reason !== exp_reason || cycle_count !== exp_count) begin
      errors++;
      $display("[TB] FAIL done_state: done=%b valid=%b busy=%b reason=%0d cnt=%0d, want 1 0 0 %0d %0d",
               done, dump_valid, busy, stop_reason, cycle_count, exp_reason, exp_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; halt_in = 1'b0; dump_ready = 1'b1; pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({cpu_run, busy, done, dump_valid, reg_sel, dump_idx, dump_data, stop_reason, cycle_count} !== 80'h0) begin
      errors++;
      $display("[TB] FAIL reset: run=%b busy=%b done=%b valid=%b sel=%0d idx=%0d data=%h reason=%0d cnt=%0d, want all 0",
               cpu_run, busy, done, dump_valid, reg_sel, dump_idx, dump_data, stop_reason, cycle_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_halt();
    start_run();
    run_cycles(10, 10, 0);
    checks++;
    if (cpu_run !== 1'b0 || busy !== 1'b1 || stop_reason !== 2'd1 || cycle_count !== 32'd10) begin
      errors++;
      $display("[TB] FAIL halt_stop: run=%b busy=%b reason=%0d cnt=%0d, want 0 1 1 10",
               cpu_run, busy, stop_reason, cycle_count);
    end
    collect_dump(-1, -1, 2'd1, 32'd10);
  endtask

  // pc reaches 0x60 in cycle 4 and is unchanged from cycle 5; 8th unchanged cycle is 12.
  task automatic test_pc_stable();
    start_run();
    run_cycles(12, 0, 4);
    checks++;
    if (cpu_run !== 1'b0 || stop_reason !== 2'd2 || cycle_count !== 32'd12) begin
      errors++;
      $display("[TB] FAIL stable_stop: run=%b reason=%0d cnt=%0d, want 0 2 12",
               cpu_run, stop_reason, cycle_count);
    end
    collect_dump(-1, -1, 2'd2, 32'd12);
  endtask

  task automatic test_timeout();
    start_run();
    run_cycles(50, 0, 0);
    checks++;
    if (cpu_run !== 1'b0 || stop_reason !== 2'd3 || cycle_count !== 32'd50) begin
      errors++;
      $display("[TB] FAIL timeout_stop: run=%b reason=%0d cnt=%0d, want 0 3 50",
               cpu_run, stop_reason, cycle_count);
    end
    collect_dump(-1, -1, 2'd3, 32'd50);
  endtask

  task automatic test_backpressure();
    start_run();
    run_cycles(3, 3, 0);
    checks++;
    if (stop_reason !== 2'd1 || cycle_count !== 32'd3) begin
      errors++;
      $display("[TB] FAIL bp_stop: reason=%0d cnt=%0d, want 1 3", stop_reason, cycle_count);
    end
    collect_dump(7, -1, 2'd1, 32'd3);
  endtask

  // Halt coincides with the last allowed cycle of the 50-cycle limit.
  task automatic test_simultaneous();
    start_run();
    run_cycles(50, 50, 0);
    checks++;
    if (stop_reason !== 2'd1 || cycle_count !== 32'd50) begin
      errors++;
      $display("[TB] FAIL simul_stop: reason=%0d cnt=%0d, want 1 50", stop_reason, cycle_count);
    end
    collect_dump(-1, -1, 2'd1, 32'd50);
  endtask

  task automatic test_reset_mid_scan();
    start_run();
    run_cycles(5, 5, 0);
    collect_dump(-1, 12, 2'd1, 32'd5);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({cpu_run, busy, done, dump_valid, reg_sel, dump_idx, dump_data, stop_reason, cycle_count} !== 80'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset: run=%b busy=%b done=%b valid=%b sel=%0d idx=%0d data=%h reason=%0d cnt=%0d, want all 0",
               cpu_run, busy, done, dump_valid, reg_sel, dump_idx, dump_data, stop_reason, cycle_count);
    end
    rst = 1'b0;
    dump_ready = 1'b1;
    @(negedge clk);
    start_run();
    run_cycles(7, 7, 0);
    checks++;
    if (stop_reason !== 2'd1 || cycle_count !== 32'd7) begin
      errors++;
      $display("[TB] FAIL rerun_stop: reason=%0d cnt=%0d, want 1 7", stop_reason, cycle_count);
    end
    collect_dump(-1, -1, 2'd1, 32'd7);
  endtask

  initial begin
    test_reset();
    test_halt();
    test_pc_stable();
    test_timeout();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
